// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and FSM state encoding for the 256x9 FIFO controller.
package fifo_ctrl_pkg;

    localparam int DW    = 9;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/fifo8x9_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; r_rr_last remembers the requester granted most recently.
module rr_arb2
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic r_rr_last;
    logic [1:0] w_gnt;

    // grant selection: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        w_gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_rr_last ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end else begin
            w_gnt = 2'b00;
        end
    end

    // last-winner register, moves only when a grant is actually issued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (|w_gnt) begin
            r_rr_last <= w_gnt[1];
        end
    end

    assign gnt = w_gnt;

endmodule

// File: rtl/fifo8x9_ctrl.sv
// Controller for the 256x9 FIFO: arbitrated write port, read sequencing,
// occupancy flags and pointer clears on start-up and flush.
module fifo8x9_ctrl #(
    parameter int DW    = fifo_ctrl_pkg::DW,
    parameter int AW    = fifo_ctrl_pkg::AW,
    parameter int DEPTH = fifo_ctrl_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_req0,
    input  logic          wr_req1,
    input  logic [DW-1:0] wr_data0,
    input  logic [DW-1:0] wr_data1,
    output logic          wr_gnt0,
    output logic          wr_gnt1,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          fifo_wren,
    output logic          fifo_wrinc,
    output logic [DW-1:0] fifo_din,
    output logic          fifo_rden,
    output logic          fifo_rdinc,
    output logic          fifo_wrptrclr,
    output logic          fifo_rdptrclr,
    input  logic [DW-1:0] fifo_dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    import fifo_ctrl_pkg::*;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_count;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic          w_run;
    logic          w_full;
    logic          w_empty;
    logic          w_rd_ack;
    logic          w_wr_en;
    logic          w_wr;
    logic [1:0]    w_gnt;

    // flush and reset both suppress every grant and ack in the cycle they are seen
    assign w_run    = (r_state == ST_RUN) && !rst && !flush;
    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == {(AW+1){1'b0}});
    assign w_rd_ack = w_run && rd_req && !w_empty;
    // at full a write is still allowed when a read frees a slot in the same cycle
    assign w_wr_en  = w_run && (!w_full || w_rd_ack);
    assign w_wr     = |w_gnt;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({wr_req1, wr_req0}),
        .en  (w_wr_en),
        .gnt (w_gnt)
    );

    // next-state logic: the clear state always lasts exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLR: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush) begin
                    w_state_nxt = ST_CLR;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_CLR;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // occupancy counter; the FIFO pointers wrap but this count never does
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_CLR)) begin
            r_count <= {(AW+1){1'b0}};
        end else begin
            case ({w_wr, w_rd_ack})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // read return: the FIFO word is taken only on the edge closing an accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= {DW{1'b0}};
        end else begin
            r_rd_valid <= w_rd_ack;
            if (w_rd_ack) begin
                r_rd_data <= fifo_dout;
            end
        end
    end

    assign wr_gnt0       = w_gnt[0];
    assign wr_gnt1       = w_gnt[1];
    assign rd_ack        = w_rd_ack;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;
    assign fifo_wren     = w_wr;
    assign fifo_wrinc    = w_wr;
    assign fifo_din      = w_gnt[1] ? wr_data1 : wr_data0;
    assign fifo_rden     = w_rd_ack;
    assign fifo_rdinc    = w_rd_ack;
    assign fifo_wrptrclr = (r_state == ST_CLR);
    assign fifo_rdptrclr = (r_state == ST_CLR);
    assign count         = r_count;
    assign full          = w_full;
    assign empty         = w_empty;

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Directed bench for fifo8x9_ctrl with a behavioural 256x9 FIFO attached.
module tb_fifo8x9_ctrl;

    logic       clk = 1'b0;
    logic       rst, flush, wr_req0, wr_req1, rd_req;
    logic [8:0] wr_data0, wr_data1;
    logic       wr_gnt0, wr_gnt1, rd_ack, rd_valid;
    logic [8:0] rd_data, fifo_din;
    logic       fifo_wren, fifo_wrinc, fifo_rden, fifo_rdinc, fifo_wrptrclr, fifo_rdptrclr;
    wire  [8:0] fifo_dout;
    logic [8:0] count;
    logic       full, empty;

    logic [8:0] mem [0:255];
    logic [7:0] m_wp, m_rp;
    int         checks = 0;
    int         errors = 0;
    logic       exp_last;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    fifo8x9_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_req0(wr_req0), .wr_req1(wr_req1), .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .fifo_wren(fifo_wren), .fifo_wrinc(fifo_wrinc),
        .fifo_din(fifo_din), .fifo_rden(fifo_rden), .fifo_rdinc(fifo_rdinc),
        .fifo_wrptrclr(fifo_wrptrclr), .fifo_rdptrclr(fifo_rdptrclr), .fifo_dout(fifo_dout),
        .count(count), .full(full), .empty(empty)
    );

    // storage model: data presented while rden is high, high-Z otherwise
    assign fifo_dout = fifo_rden ? mem[m_rp] : 9'bz;

    always @(posedge clk) begin
        if (fifo_wrptrclr) m_wp <= 8'd0;
        else if (fifo_wrinc) begin mem[m_wp] <= fifo_din; m_wp <= m_wp + 8'd1; end
        if (fifo_rdptrclr) m_rp <= 8'd0;
        else if (fifo_rdinc) m_rp <= m_rp + 8'd1;
    end

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wr_req0 = 1'b0; wr_req1 = 1'b0; rd_req = 1'b0;
        wr_data0 = 9'h000; wr_data1 = 9'h000;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; wr_req0 = 1'b1; rd_req = 1'b1; exp_last = 1'b1;
        #1;
        checks++; if (fifo_wrptrclr !== 1'b1) begin errors++; $display("FAIL rst_wrclr: got %b want 1", fifo_wrptrclr); end
        checks++; if (fifo_rdptrclr !== 1'b1) begin errors++; $display("FAIL rst_rdclr: got %b want 1", fifo_rdptrclr); end
        checks++; if (count !== 9'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags: empty %b full %b want 1 0", empty, full); end
        checks++; if (wr_gnt0 !== 1'b0 || rd_ack !== 1'b0) begin errors++; $display("FAIL rst_nognt: gnt0 %b ack %b want 0 0", wr_gnt0, rd_ack); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 9'h000) begin errors++; $display("FAIL rst_rd: valid %b data %h want 0 000", rd_valid, rd_data); end
        checks++; if (fifo_wren !== 1'b0 || fifo_rden !== 1'b0) begin errors++; $display("FAIL rst_strobe: wren %b rden %b want 0 0", fifo_wren, fifo_rden); end
        @(negedge clk); wr_req0 = 1'b0; rd_req = 1'b0;
        #1;
        checks++; if (fifo_wrptrclr !== 1'b0 || fifo_rdptrclr !== 1'b0) begin errors++; $display("FAIL run_clr: %b%b want 00", fifo_wrptrclr, fifo_rdptrclr); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); wr_req0 = 1'b1; wr_data0 = 9'(i);
            #1;
            checks++; if (wr_gnt0 !== 1'b1 || count !== 9'(i)) begin errors++; $display("FAIL fill_%0d: gnt0 %b count %0d want 1 %0d", i, wr_gnt0, count, i); end
        end
        exp_last = 1'b0;
        @(negedge clk); wr_data0 = 9'h100;
        #1;
        checks++; if (count !== 9'd256) begin errors++; $display("FAIL full_count: got %0d want 256", count); end
        checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL full_flags: full %b empty %b want 1 0", full, empty); end
        checks++; if (wr_gnt0 !== 1'b0 || fifo_wren !== 1'b0) begin errors++; $display("FAIL full_nognt: gnt0 %b wren %b want 0 0", wr_gnt0, fifo_wren); end
        @(posedge clk); #1;
        checks++; if (count !== 9'd256) begin errors++; $display("FAIL full_hold: got %0d want 256", count); end
    endtask

    task automatic test_full_simul();
        @(negedge clk); wr_req0 = 1'b0; wr_req1 = 1'b1; wr_data1 = 9'h155; rd_req = 1'b1;
        #1;
        checks++; if (wr_gnt1 !== 1'b1 || wr_gnt0 !== 1'b0) begin errors++; $display("FAIL fsim_gnt: %b%b want 10", wr_gnt1, wr_gnt0); end
        checks++; if (rd_ack !== 1'b1 || fifo_din !== 9'h155) begin errors++; $display("FAIL fsim_ack: ack %b din %h want 1 155", rd_ack, fifo_din); end
        exp_last = 1'b1;
        @(negedge clk); wr_req1 = 1'b0; rd_req = 1'b0;
        checks++; if (count !== 9'd256 || full !== 1'b1) begin errors++; $display("FAIL fsim_full: count %0d full %b want 256 1", count, full); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 9'h000) begin errors++; $display("FAIL fsim_rd: valid %b data %h want 1 000", rd_valid, rd_data); end
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1; rd_req = 1'b1;
        #1;
        checks++; if (rd_ack !== 1'b0 || fifo_wren !== 1'b0) begin errors++; $display("FAIL flush_prio: ack %b wren %b want 0 0", rd_ack, fifo_wren); end
        @(negedge clk); flush = 1'b0; rd_req = 1'b0;
        checks++; if (fifo_wrptrclr !== 1'b1 || fifo_rdptrclr !== 1'b1) begin errors++; $display("FAIL flush_clr: %b%b want 11", fifo_wrptrclr, fifo_rdptrclr); end
        @(negedge clk);
        checks++; if (count !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_cnt: count %0d empty %b want 0 1", count, empty); end
    endtask

    task automatic test_round_robin();
        logic       eg1;
        logic [8:0] ed;
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); wr_req0 = 1'b1; wr_req1 = 1'b1;
            wr_data0 = 9'h100 | 9'(k); wr_data1 = 9'h080 | 9'(k);
            #1;
            eg1 = ~exp_last;
            ed  = eg1 ? (9'h080 | 9'(k)) : (9'h100 | 9'(k));
            checks++; if ({wr_gnt1, wr_gnt0} !== {eg1, ~eg1}) begin errors++; $display("FAIL rr_gnt_%0d: got %b%b want %b%b", k, wr_gnt1, wr_gnt0, eg1, ~eg1); end
            checks++; if (fifo_din !== ed) begin errors++; $display("FAIL rr_din_%0d: got %h want %h", k, fifo_din, ed); end
            exp_last = eg1;
            exp_q.push_back(ed);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); wr_req0 = 1'b0; wr_req1 = 1'b0;
            if (k > 0) begin
                checks++; if (rd_valid !== 1'b1 || rd_data !== exp_q[k-1]) begin errors++; $display("FAIL rr_rd_%0d: valid %b data %h want 1 %h", k-1, rd_valid, rd_data, exp_q[k-1]); end
            end
            rd_req = 1'b1;
            #1;
            checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL rr_ack_%0d: got %b want 1", k, rd_ack); end
        end
        @(negedge clk); rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp_q[5]) begin errors++; $display("FAIL rr_rd_5: valid %b data %h want 1 %h", rd_valid, rd_data, exp_q[5]); end
        checks++; if (count !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL rr_empty: count %0d empty %b want 0 1", count, empty); end
    endtask

    task automatic test_empty_read();
        @(negedge clk); rd_req = 1'b1;
        #1;
        checks++; if (rd_ack !== 1'b0 || fifo_rden !== 1'b0) begin errors++; $display("FAIL er_noack: ack %b rden %b want 0 0", rd_ack, fifo_rden); end
        @(negedge clk); rd_req = 1'b0; wr_req0 = 1'b1; wr_data0 = 9'h1A5;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL er_novalid: got %b want 0", rd_valid); end
        #1;
        checks++; if (wr_gnt0 !== 1'b1) begin errors++; $display("FAIL er_wr: gnt0 %b want 1", wr_gnt0); end
        exp_last = 1'b0;
        @(negedge clk); wr_req0 = 1'b0; rd_req = 1'b1;
        #1;
        checks++; if (rd_ack !== 1'b1 || count !== 9'd1) begin errors++; $display("FAIL er_ack: ack %b count %0d want 1 1", rd_ack, count); end
        @(negedge clk); rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 9'h1A5) begin errors++; $display("FAIL er_rd: valid %b data %h want 1 1a5", rd_valid, rd_data); end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0 || rd_data !== 9'h1A5) begin errors++; $display("FAIL er_hold: valid %b data %h want 0 1a5", rd_valid, rd_data); end
    endtask

    task automatic test_count_simul();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); wr_req0 = 1'b1; wr_data0 = 9'h010 + 9'(i);
        end
        @(negedge clk); wr_data0 = 9'h0FF; rd_req = 1'b1;
        #1;
        checks++; if (count !== 9'd5 || wr_gnt0 !== 1'b1 || rd_ack !== 1'b1) begin errors++; $display("FAIL cs_pre: count %0d gnt0 %b ack %b want 5 1 1", count, wr_gnt0, rd_ack); end
        @(negedge clk); wr_req0 = 1'b0; rd_req = 1'b0;
        checks++; if (count !== 9'd5) begin errors++; $display("FAIL cs_count: got %0d want 5", count); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 9'h010) begin errors++; $display("FAIL cs_rd: valid %b data %h want 1 010", rd_valid, rd_data); end
    endtask

    task automatic test_flush_read();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); wr_req0 = 1'b1; wr_data0 = 9'h020 + 9'(i);
        end
        @(negedge clk); wr_req0 = 1'b0; rd_req = 1'b1;
        #1;
        checks++; if (count !== 9'd10 || rd_ack !== 1'b1) begin errors++; $display("FAIL fr_pre: count %0d ack %b want 10 1", count, rd_ack); end
        @(negedge clk); flush = 1'b1; wr_req0 = 1'b1; wr_data0 = 9'h1FF;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 9'h011) begin errors++; $display("FAIL fr_rd: valid %b data %h want 1 011", rd_valid, rd_data); end
        #1;
        checks++; if (rd_ack !== 1'b0 || wr_gnt0 !== 1'b0) begin errors++; $display("FAIL fr_prio: ack %b gnt0 %b want 0 0", rd_ack, wr_gnt0); end
        @(negedge clk); flush = 1'b0;
        #1;
        checks++; if (fifo_wrptrclr !== 1'b1 || fifo_rdptrclr !== 1'b1) begin errors++; $display("FAIL fr_clr: %b%b want 11", fifo_wrptrclr, fifo_rdptrclr); end
        checks++; if (rd_ack !== 1'b0 || wr_gnt0 !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL fr_clrgnt: ack %b gnt0 %b valid %b want 0 0 0", rd_ack, wr_gnt0, rd_valid); end
        @(negedge clk); rd_req = 1'b0; wr_data0 = 9'h03C;
        checks++; if (count !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL fr_count: count %0d empty %b want 0 1", count, empty); end
        #1;
        checks++; if (wr_gnt0 !== 1'b1) begin errors++; $display("FAIL fr_wr: gnt0 %b want 1", wr_gnt0); end
        @(negedge clk); wr_req0 = 1'b0; rd_req = 1'b1;
        #1;
        checks++; if (rd_ack !== 1'b1 || count !== 9'd1) begin errors++; $display("FAIL fr_ack: ack %b count %0d want 1 1", rd_ack, count); end
        @(negedge clk); rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 9'h03C) begin errors++; $display("FAIL fr_first: valid %b data %h want 1 03c", rd_valid, rd_data); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_simul();
        do_flush();
        test_round_robin();
        test_empty_read();
        test_count_simul();
        test_flush_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
